// File: rtl/clk_divgen_pkg.sv
// rtl/clk_divgen_pkg.sv - default divisors and helpers for clk_divgen
// Divisors assume a 50 MHz source clock.
package clk_divgen_pkg;

  localparam int NCH_DEFAULT = 4;
  localparam int CW_DEFAULT  = 16;

  localparam logic [CW_DEFAULT-1:0] DIV_BAUD_9600 = 16'd5208;
  localparam logic [CW_DEFAULT-1:0] DIV_10K       = 16'd5000;
  localparam logic [CW_DEFAULT-1:0] DIV_1K        = 16'd50000;
  localparam logic [CW_DEFAULT-1:0] DIV_100K      = 16'd500;

  // Channel 0 sits in the low bits: baud, 10 kHz, 1 kHz, 100 kHz.
  localparam logic [NCH_DEFAULT*CW_DEFAULT-1:0] DIV_INIT_DEFAULT =
    {DIV_100K, DIV_1K, DIV_10K, DIV_BAUD_9600};

  function automatic logic [31:0] ceil_half(input logic [31:0] d);
    return {1'b0, d[31:1]} + {31'b0, d[0]};
  endfunction

endpackage

// File: rtl/clk_divgen_ch.sv
// rtl/clk_divgen_ch.sv - one divider channel: phase counter, divisor, shadow, outputs
// Shadow/load path is built only when CLK_DIVGEN_LOAD_EN is defined.
module clk_divgen_ch
  import clk_divgen_pkg::*;
#(
  parameter int            CW       = CW_DEFAULT,
  parameter logic [CW-1:0] DIV_INIT = DIV_BAUD_9600
) (
  input  logic          clk_50M,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sync,
  input  logic          load_we,
  input  logic [CW-1:0] load_div,
  output logic          pending,
  output logic          clk_out,
  output logic          tick
);

  logic [CW-1:0] p_q, p_d;
  logic          clk_q, clk_d;
  logic          tick_q, tick_d;
  logic [CW-1:0] d_eff;
  logic [31:0]   half;

`ifdef CLK_DIVGEN_LOAD_EN
  logic [CW-1:0] d_q, d_d;
  logic [CW-1:0] s_q, s_d;
  logic          pend_q, pend_d;
  logic          apply;

  // A pending shadow is swapped in on the boundary edge itself, so it already
  // shapes that edge's outputs.
  assign apply   = en && !sync && (p_q == '0) && pend_q;
  assign d_eff   = apply ? s_q : d_q;
  assign pending = pend_q;

  always_comb begin
    d_d    = d_q;
    s_d    = s_q;
    pend_d = pend_q;
    if (apply) begin
      d_d    = s_q;
      pend_d = 1'b0;
    end
    // A write on the boundary edge lands after the old shadow is consumed.
    if (load_we) begin
      s_d    = load_div;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= DIV_INIT;
      s_q    <= '0;
      pend_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      s_q    <= s_d;
      pend_q <= pend_d;
    end
  end
`else
  logic unused_load;

  assign unused_load = ^{load_we, load_div};
  assign d_eff       = DIV_INIT;
  assign pending     = 1'b0;
`endif

  assign half = ceil_half(32'(d_eff));

  always_comb begin
    p_d    = p_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (sync) begin
      p_d   = '0;
      clk_d = 1'b0;
    end else if (en) begin
      if (d_eff == '0) begin
        p_d   = '0;
        clk_d = 1'b0;
      end else begin
        tick_d = (p_q == '0);
        clk_d  = (32'(p_q) < half);
        p_d    = (p_q == d_eff - 1'b1) ? '0 : p_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_divgen.sv
// rtl/clk_divgen.sv - multi-channel clock divider with runtime divisor reload
// Runtime reload requires CLK_DIVGEN_LOAD_EN; otherwise divisors are fixed at DIV_INIT.
module clk_divgen
  import clk_divgen_pkg::*;
#(
  parameter int                  NCH      = NCH_DEFAULT,
  parameter int                  CW       = CW_DEFAULT,
  parameter logic [NCH*CW-1:0]   DIV_INIT = DIV_INIT_DEFAULT
) (
  input  logic                     clk_50M,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           en,
  input  logic                     sync,
  input  logic                     load_we,
  input  logic [$clog2(NCH)-1:0]   load_ch,
  input  logic [CW-1:0]            load_div,
  output logic [NCH-1:0]           pending,
  output logic [NCH-1:0]           clk_out,
  output logic [NCH-1:0]           tick
);

  localparam int LCW = $clog2(NCH);

  logic [NCH-1:0] ch_we;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Channel numbers at or above NCH decode to no channel.
    assign ch_we[i] = load_we && (load_ch == LCW'(i));

    clk_divgen_ch #(
      .CW       (CW),
      .DIV_INIT (DIV_INIT[i*CW +: CW])
    ) u_ch (
      .clk_50M  (clk_50M),
      .rst_n    (rst_n),
      .en       (en[i]),
      .sync     (sync),
      .load_we  (ch_we[i]),
      .load_div (load_div),
      .pending  (pending[i]),
      .clk_out  (clk_out[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_divgen.sv
// tb/tb_clk_divgen.sv - directed bench for clk_divgen, two channels with divisors 5 and 4
// Load-path expectations depend on CLK_DIVGEN_LOAD_EN.
module tb_clk_divgen;

  localparam int NCH = 2;
  localparam int CW  = 16;

  logic           clk_50M = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           sync;
  logic           load_we;
  logic [0:0]     load_ch;
  logic [CW-1:0]  load_div;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  int n_checks = 0;
  int n_fail   = 0;

  clk_divgen #(
    .NCH      (NCH),
    .CW       (CW),
    .DIV_INIT ({16'd4, 16'd5})
  ) dut (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .en       (en),
    .sync     (sync),
    .load_we  (load_we),
    .load_ch  (load_ch),
    .load_div (load_div),
    .pending  (pending),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int div);
    load_we  = 1'b1;
    load_ch  = ch[0:0];
    load_div = div[CW-1:0];
  endtask

  task automatic step0(input logic c, input logic t, input logic pd);
    @(negedge clk_50M);
    check("ch0_clk", {31'b0, clk_out[0]}, {31'b0, c});
    check("ch0_tick", {31'b0, tick[0]}, {31'b0, t});
    check("ch0_pend", {31'b0, pending[0]}, {31'b0, pd});
    load_we = 1'b0;
  endtask

  task automatic step2(input logic [1:0] c, input logic [1:0] t);
    @(negedge clk_50M);
    check("sync_en_clk", {30'b0, clk_out}, {30'b0, c});
    check("sync_en_tick", {30'b0, tick}, {30'b0, t});
  endtask

  // Fresh-from-reset run: ch0 period 5 (3 high), ch1 period 4 (2 high).
  task automatic run_init(input int n);
    logic [1:0] ec, et;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_50M);
      ec = {((k % 4) < 2), ((k % 5) < 3)};
      et = {((k % 4) == 0), ((k % 5) == 0)};
      check("init_clk", {30'b0, clk_out}, {30'b0, ec});
      check("init_tick", {30'b0, tick}, {30'b0, et});
    end
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    en       = '0;
    sync     = 1'b0;
    load_we  = 1'b0;
    load_ch  = '0;
    load_div = '0;
    #2 rst_n = 1'b0;
    en = 2'b11;
    repeat (3) @(negedge clk_50M);
    check("rst_clk", {30'b0, clk_out}, 32'd0);
    check("rst_tick", {30'b0, tick}, 32'd0);
    check("rst_pend", {30'b0, pending}, 32'd0);

    rst_n = 1'b1;
    run_init(10);

`ifdef CLK_DIVGEN_LOAD_EN
    step0(1, 1, 0); step0(1, 0, 0);
    wr(0, 3);
    step0(1, 0, 1); step0(0, 0, 1); step0(0, 0, 1);
    step0(1, 1, 0); step0(1, 0, 0); step0(0, 0, 0); step0(1, 1, 0);
    // Race: second write lands on the boundary that consumes S=3.
    wr(0, 3);
    step0(1, 0, 1); step0(0, 0, 1);
    wr(0, 7);
    step0(1, 1, 1); step0(1, 0, 1); step0(0, 0, 1);
    step0(1, 1, 0); step0(1, 0, 0); step0(1, 0, 0); step0(1, 0, 0);
    step0(0, 0, 0); step0(0, 0, 0); step0(0, 0, 0); step0(1, 1, 0);
    wr(0, 1);
    step0(1, 0, 1); step0(1, 0, 1); step0(1, 0, 1);
    step0(0, 0, 1); step0(0, 0, 1); step0(0, 0, 1);
    step0(1, 1, 0); step0(1, 1, 0); step0(1, 1, 0); step0(1, 1, 0);
    wr(0, 0);
    step0(1, 1, 1); step0(0, 0, 0); step0(0, 0, 0); step0(0, 0, 0);
    wr(0, 4);
    step0(0, 0, 1); step0(1, 1, 0); step0(1, 0, 0); step0(0, 0, 0);
    step0(0, 0, 0); step0(1, 1, 0);
`else
    step0(1, 1, 0); step0(1, 0, 0);
    wr(0, 3);
    step0(1, 0, 0); step0(0, 0, 0);
    wr(1, 2);
    step0(0, 0, 0);
    check("pend_all", {30'b0, pending}, 32'd0);
    step0(1, 1, 0); step0(1, 0, 0); step0(1, 0, 0); step0(0, 0, 0); step0(0, 0, 0);
`endif

    // Async reset between edges must clear outputs and any pending load.
    wr(0, 9);
    @(negedge clk_50M);
    load_we = 1'b0;
`ifdef CLK_DIVGEN_LOAD_EN
    check("pend_pre_rst", {31'b0, pending[0]}, 32'd1);
`else
    check("pend_pre_rst", {31'b0, pending[0]}, 32'd0);
`endif
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_clk", {30'b0, clk_out}, 32'd0);
    check("async_rst_tick", {30'b0, tick}, 32'd0);
    check("async_rst_pend", {30'b0, pending}, 32'd0);
    @(negedge clk_50M);
    rst_n = 1'b1;
    run_init(11);

    // Channels now at different phases: ch0 p=1, ch1 p=3.
    sync = 1'b1;
    step2(2'b00, 2'b00);
    sync = 1'b0;
    step2(2'b11, 2'b11);
    step2(2'b11, 2'b00);
    en = 2'b01;
    step2(2'b11, 2'b00);
    step2(2'b10, 2'b00);
    step2(2'b10, 2'b00);
    en = 2'b11;
    step2(2'b01, 2'b01);
    step2(2'b01, 2'b00);
    step2(2'b11, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
